// File: rtl/servo_pwm_array_if.sv
// rtl/servo_pwm_array_if.sv - target/enable inputs and PWM/status outputs of servo_pwm_array
interface servo_pwm_array_if #(
  parameter int CHANNELS = 2,
  parameter int CW       = 13
);
  logic [CHANNELS*CW-1:0] target;
  logic [CHANNELS-1:0]    en;
  logic [CHANNELS-1:0]    pwm;
  logic                   frame_tick;
  logic [CHANNELS-1:0]    settled;

  modport master (output target, en, input pwm, frame_tick, settled);
  modport slave  (input target, en, output pwm, frame_tick, settled);
endinterface

// File: rtl/servo_pwm_array.sv
// rtl/servo_pwm_array.sv - multi-channel servo PWM with shared frame counter and clamped widths
// Define SERVO_SLEW_EN to limit each width change to STEP cycles per frame.
module servo_pwm_array #(
  parameter int CHANNELS  = 2,
  parameter int CW        = 13,
  parameter int PERIOD_US = 5000,
  parameter int W_MIN     = 900,
  parameter int W_MAX     = 2100,
  parameter int W_CENTER  = 1500,
  parameter int STEP      = 100
) (
  input  logic                  clkus,
  input  logic                  rst_n,
  servo_pwm_array_if.slave      bus
);

  localparam logic [CW-1:0] LAST_C   = CW'(PERIOD_US - 1);
  localparam logic [CW-1:0] W_MIN_C  = CW'(W_MIN);
  localparam logic [CW-1:0] W_MAX_C  = CW'(W_MAX);
  localparam logic [CW-1:0] W_CTR_C  = CW'(W_CENTER);

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0][CW-1:0]  width_q, width_d;
  logic [CHANNELS-1:0][CW-1:0]  width_nx;
  logic [CHANNELS-1:0][CW-1:0]  tgt_c;
  logic [CHANNELS-1:0]          en_q, en_d;
  logic [CHANNELS-1:0]          pwm_q, pwm_d;
  logic [CHANNELS-1:0]          settled_q, settled_d;
  logic                         frame_tick_q, frame_tick_d;
  logic                         fe;

`ifdef SERVO_SLEW_EN
  localparam logic [CW-1:0]   STEP_C = CW'(STEP);
  localparam logic signed [CW:0] STEP_S = (CW+1)'(STEP);
  logic signed [CW:0] diff [CHANNELS];
`endif

  always_comb begin
    fe           = (cnt_q == LAST_C);
    cnt_d        = fe ? '0 : cnt_q + CW'(1);
    frame_tick_d = fe;
    width_d      = width_q;
    en_d         = en_q;
    settled_d    = settled_q;
    pwm_d        = '0;
    tgt_c        = '0;
    width_nx     = width_q;
`ifdef SERVO_SLEW_EN
    for (int i = 0; i < CHANNELS; i++) diff[i] = '0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      tgt_c[i] = bus.target[i*CW +: CW];
      if (tgt_c[i] < W_MIN_C) tgt_c[i] = W_MIN_C;
      if (tgt_c[i] > W_MAX_C) tgt_c[i] = W_MAX_C;
`ifdef SERVO_SLEW_EN
      diff[i] = $signed({1'b0, tgt_c[i]}) - $signed({1'b0, width_q[i]});
      if (diff[i] > STEP_S)       width_nx[i] = width_q[i] + STEP_C;
      else if (diff[i] < -STEP_S) width_nx[i] = width_q[i] - STEP_C;
      else                        width_nx[i] = tgt_c[i];
`else
      width_nx[i] = tgt_c[i];
`endif
      // Old width is still used at FE; pwm is already low there so the swap is glitch-free.
      pwm_d[i] = en_q[i] && (cnt_q < width_q[i]);
      if (fe) begin
        width_d[i]   = width_nx[i];
        en_d[i]      = bus.en[i];
        settled_d[i] = (width_nx[i] == tgt_c[i]);
      end
    end
  end

  always_ff @(posedge clkus) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      width_q      <= {CHANNELS{W_CTR_C}};
      en_q         <= '0;
      pwm_q        <= '0;
      frame_tick_q <= 1'b0;
      settled_q    <= '1;
    end else begin
      cnt_q        <= cnt_d;
      width_q      <= width_d;
      en_q         <= en_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= frame_tick_d;
      settled_q    <= settled_d;
    end
  end

  assign bus.pwm        = pwm_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.settled    = settled_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// tb/tb_servo_pwm_array.sv - directed frame-level checks of servo_pwm_array
module tb_servo_pwm_array;
  localparam int CW = 13;
  localparam int P  = 5000;

  logic clkus = 1'b0;
  logic rst_n = 1'b0;
  always #5 clkus = ~clkus;

  servo_pwm_array_if #(.CHANNELS(2), .CW(CW)) bus();
  servo_pwm_array #(.CHANNELS(2), .CW(CW)) dut (.clkus(clkus), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*CW-1:0] tg(input int t0, input int t1);
    logic [CW-1:0] a, b;
    a = CW'(t0);
    b = CW'(t1);
    return {b, a};
  endfunction

  task automatic wait_tick(input string tag, output int n);
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 6000) begin
      @(negedge clkus);
      n++;
    end
    chk({tag, "_tick_seen"}, int'(bus.frame_tick), 1);
  endtask

  // One frame window from the frame_tick cycle (cnt==0) to cnt==P-1, with up to two input changes.
  task automatic measure(input string tag, input int e0, input int e1, input int er0, input int er1,
                         input int es, input int ca, input logic [1:0] ea, input logic [2*CW-1:0] ta,
                         input int cb, input logic [1:0] eb, input logic [2*CW-1:0] tb_v,
                         output int waited);
    int hi0, hi1, r0, r1, ticks;
    logic [1:0] prev;
    hi0 = 0; hi1 = 0; r0 = 0; r1 = 0; ticks = 0;
    wait_tick(tag, waited);
    chk({tag, "_settled"}, int'(bus.settled), es);
    prev = bus.pwm;
    for (int i = 0; i < P; i++) begin
      if (i == ca) begin bus.en = ea; bus.target = ta; end
      if (i == cb) begin bus.en = eb; bus.target = tb_v; end
      hi0   += int'(bus.pwm[0]);
      hi1   += int'(bus.pwm[1]);
      ticks += int'(bus.frame_tick);
      if (bus.pwm[0] && !prev[0]) r0++;
      if (bus.pwm[1] && !prev[1]) r1++;
      prev = bus.pwm;
      if (i < P - 1) @(negedge clkus);
    end
    chk({tag, "_hi0"}, hi0, e0);
    chk({tag, "_hi1"}, hi1, e1);
    chk({tag, "_rise0"}, r0, er0);
    chk({tag, "_rise1"}, r1, er1);
    chk({tag, "_ticks"}, ticks, 1);
  endtask

  int e0 [6];
  int e1 [6];
  int es [6];
  int w;
  int hi;
  int first;

  initial begin
`ifdef SERVO_SLEW_EN
    e0 = '{1600, 1700, 1800, 1900, 2000, 2100};
    e1 = '{1400, 1300, 1200, 1100, 1000, 900};
    es = '{0, 0, 0, 0, 0, 3};
`else
    e0 = '{2100, 2100, 2100, 2100, 2100, 2100};
    e1 = '{900, 900, 900, 900, 900, 900};
    es = '{3, 3, 3, 3, 3, 3};
`endif
    bus.en     = 2'b00;
    bus.target = tg(1500, 1500);
    repeat (3) @(negedge clkus);
    chk("reset_pwm", int'(bus.pwm), 0);
    chk("reset_tick", int'(bus.frame_tick), 0);
    chk("reset_settled", int'(bus.settled), 3);
    rst_n  = 1'b1;
    bus.en = 2'b11;

    // Centre width; target jumps to out-of-range values right before the frame end.
    measure("center", 1500, 1500, 1, 1, 3, P - 1, 2'b11, tg(3000, 0), -1, 2'b11, '0, w);

    for (int k = 0; k < 6; k++) begin
      measure($sformatf("clamp%0d", k), e0[k], e1[k], 1, 1, es[k], -1, 2'b11, '0, -1, 2'b11, '0, w);
      if (k == 0) chk("period_gap", w, 1);
    end

    // Disable mid-frame: this frame still full, next frame silent, re-enable at cnt 700 deferred.
    measure("dis_defer", 2100, 900, 1, 1, 3, 100, 2'b00, tg(3000, 0), -1, 2'b00, '0, w);
    measure("disabled", 0, 0, 0, 0, 3, 700, 2'b11, tg(3000, 0), -1, 2'b11, '0, w);
    measure("reenable", 2100, 900, 1, 1, 3, 2500, 2'b11, tg(950, 2000), 4000, 2'b11, tg(3000, 0), w);
    measure("glitch_ign", 2100, 900, 1, 1, 3, 4000, 2'b11, tg(1500, 1500), -1, 2'b11, '0, w);

    // Reset in the middle of a pulse.
    wait_tick("rst_frame", w);
    repeat (800) @(negedge clkus);
    chk("rst_pre_pwm", int'(bus.pwm), 3);
    rst_n = 1'b0;
    @(negedge clkus);
    chk("rst_pwm", int'(bus.pwm), 0);
    chk("rst_tick", int'(bus.frame_tick), 0);
    chk("rst_settled", int'(bus.settled), 3);
    rst_n = 1'b1;
    hi    = 0;
    first = 0;
    for (int j = 1; j <= P; j++) begin
      @(negedge clkus);
      hi += int'(bus.pwm != 2'b00);
      if (bus.frame_tick && first == 0) first = j;
    end
    chk("post_rst_quiet", hi, 0);
    chk("post_rst_tick_at", first, P);
    measure("post_rst", 1500, 1500, 1, 1, 3, -1, 2'b11, '0, -1, 2'b11, '0, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
